// File: rtl/apu_arbiter_if.sv
// Bus between N_REQ APU requesters, the arbiter and the shared accelerator port.
// The lock request lines exist only when APU_ARB_LOCK_EN is defined.
interface apu_arbiter_if #(
  parameter int unsigned N_REQ   = 2,
  parameter int unsigned OP_W    = 6,
  parameter int unsigned FLAGS_W = 15
);
  localparam int unsigned OPND_W = 96;

  // Requester side
  logic [N_REQ-1:0]         req_i;
  logic [N_REQ*OPND_W-1:0]  req_operands_i;
  logic [N_REQ*OP_W-1:0]    req_op_i;
  logic [N_REQ*FLAGS_W-1:0] req_flags_i;
`ifdef APU_ARB_LOCK_EN
  logic [N_REQ-1:0]         req_lock_i;
`endif
  logic [N_REQ-1:0]         gnt_o;
  logic [N_REQ-1:0]         rvalid_o;
  logic [31:0]              result_o;

  // Accelerator side
  logic                     acc_req_o;
  logic [OPND_W-1:0]        acc_operands_o;
  logic [OP_W-1:0]          acc_op_o;
  logic [FLAGS_W-1:0]       acc_flags_o;
  logic                     acc_gnt_i;
  logic                     acc_rvalid_i;
  logic [31:0]              acc_result_i;

  // Arbiter view
  modport slave (
`ifdef APU_ARB_LOCK_EN
    input  req_lock_i,
`endif
    input  req_i, req_operands_i, req_op_i, req_flags_i,
    output gnt_o, rvalid_o, result_o,
    output acc_req_o, acc_operands_o, acc_op_o, acc_flags_o,
    input  acc_gnt_i, acc_rvalid_i, acc_result_i
  );

  // Environment view (requesters plus accelerator)
  modport master (
`ifdef APU_ARB_LOCK_EN
    output req_lock_i,
`endif
    output req_i, req_operands_i, req_op_i, req_flags_i,
    input  gnt_o, rvalid_o, result_o,
    input  acc_req_o, acc_operands_o, acc_op_o, acc_flags_o,
    output acc_gnt_i, acc_rvalid_i, acc_result_i
  );
endinterface

// File: rtl/apu_arbiter.sv
// apu_arbiter: round-robin sharing of one APU port between N_REQ requesters.
// One instruction outstanding; owner held from grant until its result returns.
// Optional feature macro: APU_ARB_LOCK_EN (owner may keep the port for up to
// LOCK_MAX back-to-back instructions, e.g. vsetvli followed by vector ops).
module apu_arbiter #(
  parameter int unsigned N_REQ    = 2,
  parameter int unsigned OP_W     = 6,
  parameter int unsigned FLAGS_W  = 15
`ifdef APU_ARB_LOCK_EN
  , parameter int unsigned LOCK_MAX = 16
`endif
) (
  input  logic                     clk,
  input  logic                     n_reset,
  apu_arbiter_if.slave             bus,
  output logic [$clog2(N_REQ)-1:0] owner_o,
  output logic                     busy_o
);

  localparam int unsigned OWN_W  = $clog2(N_REQ);
  localparam int unsigned OPND_W = 96;
  localparam logic [OWN_W-1:0] LAST_IDX = OWN_W'(N_REQ - 1);
`ifdef APU_ARB_LOCK_EN
  localparam int unsigned LCNT_W = $clog2(LOCK_MAX + 1);
`endif

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
`ifdef APU_ARB_LOCK_EN
    , ST_HOLD = 2'd3
`endif
  } state_e;

  state_e            state_q, state_d;
  logic [OWN_W-1:0]  owner_q, owner_d;
  logic [OWN_W-1:0]  rr_q, rr_d;
`ifdef APU_ARB_LOCK_EN
  logic [LCNT_W-1:0] lock_q, lock_d;
`endif

  logic              win_found;
  logic [OWN_W-1:0]  win_idx;
  logic [OWN_W-1:0]  owner_nxt;
  logic [OWN_W-1:0]  scan;
  logic [OPND_W-1:0] own_opnd;
  logic [OP_W-1:0]   own_op;
  logic [FLAGS_W-1:0] own_flags;

  logic [N_REQ-1:0]   gnt_c;
  logic [N_REQ-1:0]   rvalid_c;
  logic [31:0]        result_c;
  logic               acc_req_c;
  logic [OPND_W-1:0]  acc_opnd_c;
  logic [OP_W-1:0]    acc_op_c;
  logic [FLAGS_W-1:0] acc_flags_c;

  // State, ownership and rotation pointer registers
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      rr_q    <= '0;
`ifdef APU_ARB_LOCK_EN
      lock_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
`ifdef APU_ARB_LOCK_EN
      lock_q  <= lock_d;
`endif
    end
  end

  // Round-robin search: first active request at or above rr_q, wrapping
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan      = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (32'(rr_q) + i >= N_REQ) begin
        scan = OWN_W'(32'(rr_q) + i - N_REQ);
      end else begin
        scan = OWN_W'(32'(rr_q) + i);
      end
      if (!win_found && bus.req_i[scan]) begin
        win_found = 1'b1;
        win_idx   = scan;
      end
    end
  end

  // Payload of the current owner
  always_comb begin
    own_opnd  = '0;
    own_op    = '0;
    own_flags = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (OWN_W'(i) == owner_q) begin
        own_opnd  = bus.req_operands_i[i*OPND_W +: OPND_W];
        own_op    = bus.req_op_i[i*OP_W +: OP_W];
        own_flags = bus.req_flags_i[i*FLAGS_W +: FLAGS_W];
      end
    end
  end

  assign owner_nxt = (owner_q == LAST_IDX) ? '0 : owner_q + OWN_W'(1);

  // Next-state logic and combinational bus routing
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_d        = rr_q;
`ifdef APU_ARB_LOCK_EN
    lock_d      = lock_q;
`endif
    gnt_c       = '0;
    rvalid_c    = '0;
    result_c    = '0;
    acc_req_c   = 1'b0;
    acc_opnd_c  = '0;
    acc_op_c    = '0;
    acc_flags_c = '0;

    case (state_q)
      ST_IDLE: begin
`ifdef APU_ARB_LOCK_EN
        lock_d = '0;
`endif
        if (win_found) begin
          owner_d = win_idx;
          state_d = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        acc_req_c      = bus.req_i[owner_q];
        acc_opnd_c     = own_opnd;
        acc_op_c       = own_op;
        acc_flags_c    = own_flags;
        gnt_c[owner_q] = bus.acc_gnt_i & bus.req_i[owner_q];
        if (!bus.req_i[owner_q]) begin
          // Owner withdrew before handshake; pointer stays so it keeps its turn
          state_d = ST_IDLE;
`ifdef APU_ARB_LOCK_EN
          lock_d  = '0;
`endif
        end else if (bus.acc_gnt_i) begin
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        rvalid_c[owner_q] = bus.acc_rvalid_i;
        if (bus.acc_rvalid_i) begin
          result_c = bus.acc_result_i;
`ifdef APU_ARB_LOCK_EN
          if (bus.req_lock_i[owner_q] && (lock_q < LCNT_W'(LOCK_MAX - 1))) begin
            lock_d  = lock_q + LCNT_W'(1);
            state_d = ST_HOLD;
          end else begin
            rr_d    = owner_nxt;
            lock_d  = '0;
            state_d = ST_IDLE;
          end
`else
          rr_d    = owner_nxt;
          state_d = ST_IDLE;
`endif
        end
      end

`ifdef APU_ARB_LOCK_EN
      // Locked owner keeps the port between instructions
      ST_HOLD: begin
        if (bus.req_i[owner_q]) begin
          state_d = ST_ISSUE;
        end else if (!bus.req_lock_i[owner_q]) begin
          rr_d    = owner_nxt;
          lock_d  = '0;
          state_d = ST_IDLE;
        end
      end
`endif

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.gnt_o          = gnt_c;
  assign bus.rvalid_o       = rvalid_c;
  assign bus.result_o       = result_c;
  assign bus.acc_req_o      = acc_req_c;
  assign bus.acc_operands_o = acc_opnd_c;
  assign bus.acc_op_o       = acc_op_c;
  assign bus.acc_flags_o    = acc_flags_c;
  assign owner_o            = owner_q;
  assign busy_o             = (state_q != ST_IDLE);

endmodule
